// File: rtl/fredkin_result_stage.sv
// Result stage behind the Fredkin gate: checks P/Q/R against A/B/C, buffers
// {P, Q, R, mismatch mask} in a small FIFO and counts sets that had any mismatch.
module fredkin_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] r_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] err_mask,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] p_mem [DEPTH];
  logic [WIDTH-1:0] q_mem [DEPTH];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] m_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] mask;
  logic             push, pop;

  // Per-bit Fredkin check: P = A, and A selects whether B/C are swapped into Q/R.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_check
      logic exp_q, exp_r;
      assign exp_q    = a_in[gi] ? c_in[gi] : b_in[gi];
      assign exp_r    = a_in[gi] ? b_in[gi] : c_in[gi];
      assign mask[gi] = (p_in[gi] ^ a_in[gi]) | (q_in[gi] ^ exp_q) | (r_in[gi] ^ exp_r);
    end
  endgenerate

  assign in_ready   = (level_reg < LW'(DEPTH));
  assign out_valid  = (level_reg != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign fifo_level = level_reg;
  assign err_cnt    = cnt_reg;

  assign p_out    = out_valid ? p_mem[rd_ptr_reg] : '0;
  assign q_out    = out_valid ? q_mem[rd_ptr_reg] : '0;
  assign r_out    = out_valid ? r_mem[rd_ptr_reg] : '0;
  assign err_mask = out_valid ? m_mem[rd_ptr_reg] : '0;
  assign err_flag = |err_mask;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    cnt_next    = cnt_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
    // Clear takes priority over a same-cycle increment; counter sticks at all-ones.
    if (cnt_clr)
      cnt_next = '0;
    else if (push && (mask != '0) && !(&cnt_reg))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Storage is not reset: stale entries are unreachable once the level is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      p_mem[wr_ptr_reg] <= p_in;
      q_mem[wr_ptr_reg] <= q_in;
      r_mem[wr_ptr_reg] <= r_in;
      m_mem[wr_ptr_reg] <= mask;
    end
  end

endmodule

// File: tb/tb_fredkin_result_stage.sv
// Directed bench for fredkin_result_stage: vector table for the check logic,
// plus sequences for full FIFO, streaming, counter saturation and async reset.
module tb_fredkin_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cnt_clr;
  logic [31:0] a_in, b_in, c_in, p_in, q_in, r_in;
  logic        in_ready, out_valid, err_flag;
  logic [31:0] p_out, q_out, r_out, err_mask;
  logic [15:0] err_cnt;
  logic [2:0]  fifo_level;

  logic        in_ready_4, out_valid_4, err_flag_4;
  logic [31:0] p_out_4, q_out_4, r_out_4, err_mask_4;
  logic [3:0]  err_cnt_4;
  logic [2:0]  fifo_level_4;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fredkin_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .p_in(p_in), .q_in(q_in), .r_in(r_in),
    .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out), .q_out(q_out),
    .r_out(r_out), .err_mask(err_mask), .err_flag(err_flag), .err_cnt(err_cnt),
    .cnt_clr(cnt_clr), .fifo_level(fifo_level)
  );

  fredkin_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .p_in(p_in), .q_in(q_in), .r_in(r_in),
    .out_valid(out_valid_4), .out_ready(out_ready), .p_out(p_out_4), .q_out(q_out_4),
    .r_out(r_out_4), .err_mask(err_mask_4), .err_flag(err_flag_4), .err_cnt(err_cnt_4),
    .cnt_clr(cnt_clr), .fifo_level(fifo_level_4)
  );

  typedef struct {
    logic [31:0] a, b, c, p, q, r;
    logic [31:0] mask;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, b, c, p, q, r);
    a_in = a; b_in = b; c_in = c; p_in = p; q_in = q; r_in = r;
  endtask

  initial begin
    // Expected Q/R worked out by hand from the Fredkin equations.
    vecs[0] = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA, 32'h0};
    vecs[1] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h00000000, 32'h11111111, 32'h22222222, 32'h0};
    vecs[2] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h00000000, 32'h11111110, 32'h22222222, 32'h00000001};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF8, 32'hFFFFFFF7, 32'h0};
    vecs[4] = '{32'hF0F0F0F0, 32'h00000000, 32'hFFFFFFFF, 32'hF0F0F0F1, 32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F1};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst fifo_level", 32'(fifo_level), 32'd0);
    check("rst p_out", p_out, 32'd0);
    check("rst err_flag", 32'(err_flag), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Vector table: single push into an empty FIFO, then pop.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].p, vecs[i].q, vecs[i].r);
      in_valid = 1'b1; out_ready = 1'b0;
      check("pre-push out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      if (vecs[i].mask != 0) exp_cnt++;
      in_valid = 1'b0; out_ready = 1'b1;
      check("vec out_valid", 32'(out_valid), 32'd1);
      check("vec fifo_level", 32'(fifo_level), 32'd1);
      check("vec p_out", p_out, vecs[i].p);
      check("vec q_out", q_out, vecs[i].q);
      check("vec r_out", r_out, vecs[i].r);
      check("vec err_mask", err_mask, vecs[i].mask);
      check("vec err_flag", 32'(err_flag), 32'(vecs[i].mask != 0));
      check("vec err_cnt", 32'(err_cnt), 32'(exp_cnt));
      $display("[TB] vec %0d p=%h q=%h r=%h mask=%h cnt=%0d", i, p_out, q_out, r_out, err_mask, err_cnt);
      @(negedge clk);
      check("vec popped out_valid", 32'(out_valid), 32'd0);
      check("vec empty q_out", q_out, 32'd0);
    end

    // Fill to DEPTH with out_ready low, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h100 + k, 32'h200 + k, 0, 32'h100 + k, 32'h200 + k);
      in_valid = 1'b1;
      @(negedge clk);
      $display("[TB] fill push %0d level=%0d", k, fifo_level);
    end
    check("full fifo_level", 32'(fifo_level), 32'd4);
    check("full in_ready", 32'(in_ready), 32'd0);
    drive(0, 32'h104, 32'h204, 0, 32'h104, 32'h204);
    @(negedge clk);
    check("full 5th rejected level", 32'(fifo_level), 32'd4);
    check("full head q_out", q_out, 32'h100);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("after pop in_ready", 32'(in_ready), 32'd1);
    check("after pop level", 32'(fifo_level), 32'd3);
    for (int k = 1; k < 4; k++) begin
      check("drain order q_out", q_out, 32'h100 + k);
      check("drain order r_out", r_out, 32'h200 + k);
      $display("[TB] drain entry %0d q=%h", k, q_out);
      @(negedge clk);
    end
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Streaming: one set per cycle, level holds at 1.
    drive(32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF8, 32'hFFFFFFF7);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stream level", 32'(fifo_level), 32'd1);
      check("stream q_out", q_out, 32'h9ABCDEF8);
      $display("[TB] stream %0d level=%0d q=%h", k, fifo_level, q_out);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream drained", 32'(fifo_level), 32'd0);
    check("stream err_cnt", 32'(err_cnt), 32'(exp_cnt));

    // Counter saturation on the CNT_W=4 instance, then clear beats increment.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr err_cnt", 32'(err_cnt), 32'd0);
    check("clr err_cnt_4", 32'(err_cnt_4), 32'd0);
    drive(0, 0, 0, 32'h1, 0, 0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15) check("sat reach 15", 32'(err_cnt_4), 32'd15);
      $display("[TB] bad push %0d cnt16=%0d cnt4=%0d", k, err_cnt, err_cnt_4);
    end
    check("sat err_cnt_4", 32'(err_cnt_4), 32'd15);
    check("nosat err_cnt", 32'(err_cnt), 32'd17);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; in_valid = 1'b0;
    check("clr wins err_cnt_4", 32'(err_cnt_4), 32'd0);
    check("clr wins err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    check("post clr level", 32'(fifo_level), 32'd0);

    // Asynchronous reset with three entries held.
    drive(32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA);
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset level", 32'(fifo_level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst level", 32'(fifo_level), 32'd0);
    check("async rst p_out", p_out, 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    $display("[TB] async reset level=%0d out_valid=%0d", fifo_level, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fredkin_result_stage.md
Name: fredkin_result_stage

Overview:
Downstream stage of the Fredkin gate in the reversible-logic ALU datapath. Each cycle it can accept one operand set (A, B, C) together with the gate's outputs (P, Q, R). It checks the outputs bitwise against the Fredkin equations, records a per-bit mismatch mask, and buffers the results in a small FIFO. The buffered results are presented to the ALU result bus through a valid/ready handshake, and the stage keeps a saturating error counter.

Parameters:
WIDTH, 32, datapath width of A/B/C/P/Q/R.
DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
CNT_W, 16, width of the error counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream presents a valid set.
in_ready  output  1  stage can accept a set.
a_in, b_in, c_in  input  WIDTH each  gate inputs A, B, C.
p_in, q_in, r_in  input  WIDTH each  gate outputs P, Q, R.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head entry.
p_out, q_out, r_out  output  WIDTH each  head entry P, Q, R.
err_mask  output  WIDTH  head entry mismatch mask.
err_flag  output  1  OR-reduction of err_mask.
err_cnt  output  CNT_W  count of accepted sets with any mismatch.
cnt_clr  input  1  synchronous clear of err_cnt.
fifo_level  output  clog2(DEPTH)+1  number of entries held.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, pointers 0, fifo_level=0, err_cnt=0.
- Outputs during reset: out_valid=0, in_ready=1; p_out/q_out/r_out/err_mask=0; err_flag=0.
- Handshake events: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (fifo_level < DEPTH). It is registered-state only and has no combinational path from out_ready.
- out_valid = (fifo_level != 0).
- Expected outputs, computed combinationally on the inputs at push:
  - expP = a_in.
  - expQ = (~a_in & b_in) | (a_in & c_in).
  - expR = (~a_in & c_in) | (a_in & b_in).
  - mask = (p_in^expP) | (q_in^expQ) | (r_in^expR).
- A push stores {p_in, q_in, r_in, mask} at wr_ptr. Pointers wrap modulo DEPTH.
- Head outputs: p_out/q_out/r_out/err_mask show the entry at rd_ptr while out_valid=1, and are forced to 0 while empty. err_flag = |err_mask.
- Latency: a set pushed at edge N gives out_valid=1 after edge N (visible in cycle N+1). There is no empty-FIFO bypass.
- Push and pop in the same cycle: both occur and fifo_level is unchanged. This applies when the FIFO is neither empty nor full.
- Full: in_ready=0, so a pop in that cycle frees one entry and in_ready rises the next cycle. Upstream must hold in_valid and its data stable until accepted.
- Empty: pop is impossible. A same-cycle push lands, and out_valid rises the next cycle.
- Outputs are stable while out_valid=1 and out_ready=0.
- err_cnt:
  - Increments by 1 on a push with mask != 0.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0 next edge; clear wins over a same-cycle increment.
- Reset asserted mid-operation discards all entries immediately. No partial state survives.
- There is no data-dependent stall; throughput is 1 set/cycle when out_ready is held at 1.

Test Plan:
1. Reset, then A=FFFFFFFF, B=AAAAAAAA, C=55555555, P=FFFFFFFF, Q=55555555, R=AAAAAAAA, single push with out_ready=1 -> next cycle out_valid=1, q_out=55555555, r_out=AAAAAAAA, err_mask=0, err_cnt=0.
2. A=00000000, B=11111111, C=22222222, P=0, Q=11111111, R=22222222 -> err_flag=0. Repeat with Q=11111110 -> err_mask=00000001, err_flag=1, err_cnt=1.
3. out_ready=0, push 4 valid sets (DEPTH=4) -> fifo_level=4, in_ready=0; a 5th in_valid is not accepted. Then out_ready=1 -> entries pop in push order, in_ready=1 one cycle after the first pop.
4. Streaming: in_valid=1 and out_ready=1 for 20 cycles with A=12345678, B=9ABCDEF0, C=FFFFFFFF and correct P/Q/R -> fifo_level stays 1, 20 entries delivered in order, err_cnt=0.
5. CNT_W=4: push 17 mismatched sets -> err_cnt=15 (saturated). Then cnt_clr=1 together with a mismatched push -> err_cnt=0.
6. Reset mid-stream: assert rst_n=0 between clock edges with fifo_level=3 -> out_valid=0, fifo_level=0, p_out=0 immediately, with no clock edge needed.
